// File: rtl/nios_system_tec2_key_in.sv
// nios_system_tec2_key_in
//   Avalon-MM input PIO for push-buttons. Synchronizes in_port, exposes the
//   synchronized level, latches selected edges in a sticky edge-capture
//   register and drives a maskable level interrupt.
//
//   Register map (word address):
//     0 data (sync level, RO)  1 reserved (reads 0)
//     2 irqmask (RW)           3 edgecapture (read / write-to-clear)
//
//   Ports:
//     clk, reset     clock, asynchronous active-high reset
//     address        word address
//     chipselect     slave select
//     read_n         read strobe (accepted, does not gate the read mux)
//     write_n        active-low write strobe
//     writedata      write data, bits at and above WIDTH ignored
//     readdata       registered read data, zero-extended
//     in_port        asynchronous external inputs
//     irq            |(edgecapture & irqmask)
//
//   Build option: NIOS_KEY_BIT_CLEAR_EN
//     defined   -> write to address 3 clears only bits written as 1
//     undefined -> any write to address 3 clears the whole register
module nios_system_tec2_key_in #(
  parameter int WIDTH      = 4,
  parameter int EDGE_TYPE  = 1,
  parameter int ARM_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] r_sync1, r_sync2, r_prev;
  logic [WIDTH-1:0] r_irqmask, r_edgecap;
  logic [3:0]       r_arm;
  logic [31:0]      r_readdata;

  logic             w_armed;
  logic             w_wr;
  logic [WIDTH-1:0] w_edge_raw, w_edge, w_clr, w_rd_mux;
  logic             w_unused;

  // read_n is accepted only for interconnect compatibility
  assign w_unused = read_n;

  // three-rank input path; r_prev is the previous synchronized level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // arm counter: saturates at ARM_CYCLES; hides the edges created while the
  // zero-reset synchronizer fills with the real input level
  assign w_armed = (r_arm == 4'(ARM_CYCLES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_arm <= '0;
    else if (!w_armed) r_arm <= r_arm + 4'd1;
  end

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign w_edge_raw = r_sync2 & ~r_prev;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign w_edge_raw = ~r_sync2 & r_prev;
    end else begin : g_any
      assign w_edge_raw = r_sync2 ^ r_prev;
    end
  endgenerate

  assign w_edge = w_armed ? w_edge_raw : '0;

  assign w_wr = chipselect & ~write_n;

`ifdef NIOS_KEY_BIT_CLEAR_EN
  assign w_clr = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
`else
  assign w_clr = (w_wr && address == 2'd3) ? '1 : '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irqmask <= '0;
      r_edgecap <= '0;
    end else begin
      if (w_wr && address == 2'd2) r_irqmask <= writedata[WIDTH-1:0];
      // set is OR-ed after the clear so a same-cycle edge survives
      r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      2'd0:    w_rd_mux = r_sync2;
      2'd2:    w_rd_mux = r_irqmask;
      2'd3:    w_rd_mux = r_edgecap;
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_readdata <= '0;
    else       r_readdata <= 32'(w_rd_mux);
  end

  assign readdata = r_readdata;
  assign irq      = |(r_edgecap & r_irqmask);

endmodule
